// File: rtl/fp_sub_core_arbiter_if.sv
// Requester-side and core-side bus of the shared float64 subtract core arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface fp_sub_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_zsign;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;
  logic                      core_start;
  logic                      core_ready;
  logic                      core_done;
  logic [DATA_W-1:0]         core_a;
  logic [DATA_W-1:0]         core_b;
  logic                      core_zsign;
  logic [DATA_W-1:0]         core_result;

  modport master (
    input  req_valid, req_a, req_b, req_zsign,
    input  core_ready, core_done, core_result,
    output req_ready, resp_valid, resp_data, resp_err,
    output core_start, core_a, core_b, core_zsign
  );

  modport slave (
    output req_valid, req_a, req_b, req_zsign,
    output core_ready, core_done, core_result,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  core_start, core_a, core_b, core_zsign
  );
endinterface

// File: rtl/fp_sub_core_arbiter.sv
// Round-robin arbiter sharing one multi-cycle float64 subtract core among
// NUM_REQ requesters, with a watchdog that aborts a stuck core call.
module fp_sub_core_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  fp_sub_core_arbiter_if.master bus,
  output logic                  busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(64'h7FF8_0000_0000_0000);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [15:0]       wdog_q, wdog_d;
  logic              core_start_q, core_start_d;
  logic [DATA_W-1:0] core_a_q, core_a_d;
  logic [DATA_W-1:0] core_b_q, core_b_d;
  logic              core_zsign_q, core_zsign_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [DATA_W-1:0] lane_a [NUM_REQ];
  logic [DATA_W-1:0] lane_b [NUM_REQ];
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [15:0]       wdog_sat;
  logic              timeout_hit;

  // req_ready is gated by reset so no grant is offered that cannot be taken.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign lane_a[gi]         = bus.req_a[gi*DATA_W +: DATA_W];
    assign lane_b[gi]         = bus.req_b[gi*DATA_W +: DATA_W];
    assign bus.req_ready[gi]  = ap_rst_n && (state_q == IDLE) && win_found &&
                                (win_idx == IDX_W'(gi));
    assign bus.resp_valid[gi] = (state_q == RESP) && (owner_q == IDX_W'(gi));
  end

  // Descending scan: the last hit written is the nearest lane at or after rr_ptr.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (bus.req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign wdog_sat    = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
  assign timeout_hit = ({1'b0, wdog_q} + 17'd1) >= 17'(TIMEOUT_CYC);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    wdog_d       = wdog_q;
    core_start_d = core_start_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_zsign_d = core_zsign_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          core_a_d     = lane_a[win_idx];
          core_b_d     = lane_b[win_idx];
          core_zsign_d = bus.req_zsign[win_idx];
          owner_d      = win_idx;
          wdog_d       = '0;
          core_start_d = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        wdog_d = wdog_sat;
        if (bus.core_ready && bus.core_done) begin
          core_start_d = 1'b0;
          resp_data_d  = bus.core_result;
          resp_err_d   = 1'b0;
          state_d      = RESP;
        end else if (timeout_hit) begin
          core_start_d = 1'b0;
          resp_data_d  = ABORT_DATA;
          resp_err_d   = 1'b1;
          state_d      = RESP;
        end else if (bus.core_ready) begin
          core_start_d = 1'b0;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        wdog_d = wdog_sat;
        if (bus.core_done) begin
          resp_data_d = bus.core_result;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end else if (timeout_hit) begin
          resp_data_d = ABORT_DATA;
          resp_err_d  = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wdog_q       <= '0;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_zsign_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wdog_q       <= wdog_d;
      core_start_q <= core_start_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_zsign_q <= core_zsign_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.core_start = core_start_q;
  assign bus.core_a     = core_a_q;
  assign bus.core_b     = core_b_q;
  assign bus.core_zsign = core_zsign_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: doc/fp_sub_core_arbiter.md
Name: fp_sub_core_arbiter

Overview:
- Shares one multi-cycle float64 subtract core (subFloat64Sigs-style ap_start/ap_ready/ap_done handshake) among NUM_REQ requesters.
- Arbitration is round-robin. Each granted request has its operands captured, is sequenced through the core, and its result is returned to the originating requester.
- A watchdog aborts a stuck core call and returns an error response.
- Sits between the per-lane test/compare controllers and the single shared core instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 64, operand/result width.
- TIMEOUT_CYC, 255, maximum core cycles from ISSUE entry before abort (1..65535).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until its req_ready pulse.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- req_a  in  NUM_REQ*DATA_W  operand a, lane i at [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand b, same packing.
- req_zsign  in  NUM_REQ  result sign per lane.
- resp_valid  out  NUM_REQ  one-hot, one-cycle result strobe.
- resp_data  out  DATA_W  result, valid with resp_valid.
- resp_err  out  1  timeout flag, valid with resp_valid.
- core_start  out  1  to core ap_start.
- core_ready  in  1  from core ap_ready.
- core_done  in  1  from core ap_done.
- core_a  out  DATA_W  latched operand a.
- core_b  out  DATA_W  latched operand b.
- core_zsign  out  1  latched zSign.
- core_result  in  DATA_W  core ap_return.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, ap_rst_n=0): state=IDLE, rr_ptr=0, wdog=0.
- Reset values of outputs: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, core_start=0, core_a=0, core_b=0, core_zsign=0, busy=0.
- Reset mid-operation discards the in-flight request; no response is produced. The requester must re-request.
- State IDLE:
  - Winner g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If a winner exists: req_ready[g]=1 (combinational, this cycle only). On the edge: latch req_a/b/zsign[g] into core_a/b/zsign, store owner=g, wdog=0, go to ISSUE.
  - req_ready is 0 in all other states.
- State ISSUE:
  - core_start=1 (registered: rises on the edge entering ISSUE).
  - On a cycle with core_ready=1: core_start clears on that edge.
    - If core_done=1 in the same cycle: go to RESP.
    - Else: go to WAIT.
- State WAIT:
  - core_start=0.
  - core_done=1 → capture core_result into resp_data, resp_err=0, go to RESP.
- Watchdog:
  - wdog increments every cycle in ISSUE/WAIT (saturating 16-bit).
  - When wdog reaches TIMEOUT_CYC without completion: core_start=0, resp_data=64'h7FF8_0000_0000_0000, resp_err=1, go to RESP.
  - core_done arriving in the same cycle as the timeout has priority: normal result, err=0.
- State RESP:
  - resp_valid[owner]=1 for exactly one cycle, resp_data/resp_err stable.
  - rr_ptr=(owner+1) mod NUM_REQ. Go to IDLE.
- Minimum latency: request accepted at cycle 0; ISSUE at 1; with a same-cycle core ready+done at cycle 1, resp_valid at cycle 2; next grant possible at cycle 3.
- core_done seen while in IDLE or RESP is ignored.
- A requester that drops req_valid before its grant is simply skipped.
- Operand changes after grant do not affect the in-flight operation.
- Only one operation is outstanding at a time.

Test Plan:
- Single lane 1: a=0x4008000000000000, b=0x3FF0000000000000, zsign=0. Core model returns 0x4000000000000000 after 5 cycles → req_ready[1] at t0; core_start high one cycle; resp_valid=4'b0010, resp_data=0x4000000000000000, resp_err=0.
- All four req_valid high from reset, held until each is granted → grants in order 0,1,2,3. Each resp_valid matches its owner; operands on core_a match the lane.
- After lane 2 is served (rr_ptr=3), lanes 0 and 3 request together → lane 3 granted first, then lane 0.
- Core ready and done asserted together in the first ISSUE cycle → WAIT skipped; resp_valid exactly 2 cycles after the grant.
- TIMEOUT_CYC=10, core never asserts done → resp_valid after 10 ISSUE/WAIT cycles, resp_data=0x7FF8000000000000, resp_err=1; next grant proceeds normally.
- ap_rst_n pulsed low during WAIT → all outputs zero immediately; no resp_valid for the dropped request; after release, lane 0 is granted first.
